// File: rtl/p_hardisc.sv
// rtl/p_hardisc.sv - shared aligner state type and compressed-instruction test
package p_hardisc;

  typedef enum logic {
    ALIGN_EMPTY = 1'b0,
    ALIGN_HALF  = 1'b1
  } align_state;

  function automatic logic is_rvc(input logic [1:0] op);
    return (op != 2'b11);
  endfunction

endpackage

// File: rtl/rvc_aligner.sv
// rtl/rvc_aligner.sv - splits fetch words into 16/32-bit instructions with PC tracking
module rvc_aligner
  import p_hardisc::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        s_clk_i,
  input  logic        s_resetn_i,
  input  logic        s_flush_i,
  input  logic [31:0] s_flush_addr_i,
  input  logic [31:0] s_fetch_data_i,
  input  logic        s_fetch_err_i,
  input  logic        s_fetch_val_i,
  output logic        s_fetch_rdy_o,
  output logic [31:0] s_instr_o,
  output logic        s_instr_rvc_o,
  output logic        s_instr_err_o,
  output logic [31:0] s_instr_pc_o,
  output logic        s_instr_val_o,
  input  logic        s_instr_rdy_i
);

  align_state  state_q, state_d;
  logic [15:0] hold_q, hold_d;
  logic        hold_err_q, hold_err_d;
  logic        skip_q, skip_d;
  logic [31:1] pc_q, pc_d;

  logic [15:0] lo, hi;
  logic        val, frdy, rvc, err;
  logic [31:0] instr;
  logic        xfer;

  // Bit 0 of a redirect target has no meaning for halfword-aligned code.
  logic unused_addr_bit;
  assign unused_addr_bit = s_flush_addr_i[0];

  assign lo = s_fetch_data_i[15:0];
  assign hi = s_fetch_data_i[31:16];
  assign xfer = val & s_instr_rdy_i;

  // Next-state and output selection; flush overrides everything.
  always_comb begin
    val        = 1'b0;
    frdy       = 1'b0;
    rvc        = 1'b0;
    err        = 1'b0;
    instr      = 32'h0;
    state_d    = state_q;
    hold_d     = hold_q;
    hold_err_d = hold_err_q;
    skip_d     = skip_q;
    pc_d       = pc_q;
    if (s_flush_i) begin
      frdy    = s_fetch_val_i;
      state_d = ALIGN_EMPTY;
      skip_d  = s_flush_addr_i[1];
      pc_d    = s_flush_addr_i[31:1];
    end else begin
      case (state_q)
        ALIGN_EMPTY: begin
          if (s_fetch_val_i) begin
            if (skip_q) begin
              // Redirect into the upper halfword: drop lo, keep hi.
              frdy       = 1'b1;
              hold_d     = hi;
              hold_err_d = s_fetch_err_i;
              skip_d     = 1'b0;
              state_d    = ALIGN_HALF;
            end else if (is_rvc(lo[1:0])) begin
              val   = 1'b1;
              rvc   = 1'b1;
              err   = s_fetch_err_i;
              instr = {16'h0, lo};
              if (xfer) begin
                frdy       = 1'b1;
                hold_d     = hi;
                hold_err_d = s_fetch_err_i;
                state_d    = ALIGN_HALF;
                pc_d       = pc_q + 31'd1;
              end
            end else begin
              val   = 1'b1;
              err   = s_fetch_err_i;
              instr = s_fetch_data_i;
              if (xfer) begin
                frdy = 1'b1;
                pc_d = pc_q + 31'd2;
              end
            end
          end
        end
        ALIGN_HALF: begin
          if (is_rvc(hold_q[1:0])) begin
            // Held compressed instruction drains without touching fetch.
            val   = 1'b1;
            rvc   = 1'b1;
            err   = hold_err_q;
            instr = {16'h0, hold_q};
            if (xfer) begin
              state_d = ALIGN_EMPTY;
              pc_d    = pc_q + 31'd1;
            end
          end else if (s_fetch_val_i) begin
            // Straddling instruction: held upper half of the previous word
            // forms the low half; this word's hi becomes the new hold.
            val   = 1'b1;
            err   = hold_err_q | s_fetch_err_i;
            instr = {lo, hold_q};
            if (xfer) begin
              frdy       = 1'b1;
              hold_d     = hi;
              hold_err_d = s_fetch_err_i;
              pc_d       = pc_q + 31'd2;
            end
          end
        end
        default: state_d = ALIGN_EMPTY;
      endcase
    end
  end

  // Outputs are forced quiet while reset is held.
  always_comb begin
    s_instr_val_o = s_resetn_i & val;
    s_fetch_rdy_o = s_resetn_i & frdy;
    s_instr_o     = s_resetn_i ? instr : 32'h0;
    s_instr_rvc_o = s_resetn_i & rvc;
    s_instr_err_o = s_resetn_i & err;
    s_instr_pc_o  = {pc_q, 1'b0};
  end

  // Aligner state registers.
  always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
    if (!s_resetn_i) begin
      state_q    <= ALIGN_EMPTY;
      hold_q     <= 16'h0;
      hold_err_q <= 1'b0;
      skip_q     <= RESET_PC[1];
      pc_q       <= RESET_PC[31:1];
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      hold_err_q <= hold_err_d;
      skip_q     <= skip_d;
      pc_q       <= pc_d;
    end
  end

endmodule

// File: tb/tb_rvc_aligner.sv
// tb/tb_rvc_aligner.sv - table-driven bench with a transfer scoreboard
module tb_rvc_aligner;

  logic        clk = 1'b0;
  logic        resetn;
  logic        flush;
  logic [31:0] flush_addr;
  logic [31:0] fetch_data;
  logic        fetch_err;
  logic        fetch_val;
  logic        fetch_rdy;
  logic [31:0] instr;
  logic        instr_rvc;
  logic        instr_err;
  logic [31:0] instr_pc;
  logic        instr_val;
  logic        instr_rdy;

  rvc_aligner #(.RESET_PC(32'h0000_0000)) dut (
    .s_clk_i        (clk),
    .s_resetn_i     (resetn),
    .s_flush_i      (flush),
    .s_flush_addr_i (flush_addr),
    .s_fetch_data_i (fetch_data),
    .s_fetch_err_i  (fetch_err),
    .s_fetch_val_i  (fetch_val),
    .s_fetch_rdy_o  (fetch_rdy),
    .s_instr_o      (instr),
    .s_instr_rvc_o  (instr_rvc),
    .s_instr_err_o  (instr_err),
    .s_instr_pc_o   (instr_pc),
    .s_instr_val_o  (instr_val),
    .s_instr_rdy_i  (instr_rdy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        flush;
    logic [31:0] faddr;
    logic [31:0] fdata;
    logic        ferr;
    logic        fval;
    logic        irdy;
    logic        eval;
    logic [31:0] einstr;
    logic        erv;
    logic        eerr;
    logic [31:0] epc;
    logic        efrdy;
  } vec_t;

  typedef struct {
    logic [31:0] instr;
    logic        rvc;
    logic        err;
    logic [31:0] pc;
  } exp_t;

  vec_t vecs[$];
  exp_t sbq[$];
  int   n_chk = 0;
  int   n_fail = 0;

  function automatic vec_t mk(logic fl, logic [31:0] fa, logic [31:0] fd, logic fe, logic fv,
                              logic ir, logic ev, logic [31:0] ei, logic er, logic ee,
                              logic [31:0] ep, logic ef);
    vec_t v;
    v.flush = fl; v.faddr = fa; v.fdata = fd; v.ferr = fe; v.fval = fv; v.irdy = ir;
    v.eval = ev; v.einstr = ei; v.erv = er; v.eerr = ee; v.epc = ep; v.efrdy = ef;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of stimulus at the falling edge and check before the rising edge.
  task automatic apply(vec_t v, string tag);
    exp_t e;
    @(negedge clk);
    flush      = v.flush;
    flush_addr = v.faddr;
    fetch_data = v.fdata;
    fetch_err  = v.ferr;
    fetch_val  = v.fval;
    instr_rdy  = v.irdy;
    if (v.eval && v.irdy) begin
      e.instr = v.einstr; e.rvc = v.erv; e.err = v.eerr; e.pc = v.epc;
      sbq.push_back(e);
    end
    #2;
    chk({tag, " val"}, {31'h0, instr_val}, {31'h0, v.eval});
    chk({tag, " fetch_rdy"}, {31'h0, fetch_rdy}, {31'h0, v.efrdy});
    if (v.eval) begin
      chk({tag, " instr"}, instr, v.einstr);
      chk({tag, " pc"}, instr_pc, v.epc);
    end
    if (instr_val && instr_rdy) begin
      if (sbq.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL %s unexpected transfer: got instr %h expected none", tag, instr);
      end else begin
        e = sbq.pop_front();
        chk({tag, " sb instr"}, instr, e.instr);
        chk({tag, " sb rvc"}, {31'h0, instr_rvc}, {31'h0, e.rvc});
        chk({tag, " sb err"}, {31'h0, instr_err}, {31'h0, e.err});
        chk({tag, " sb pc"}, instr_pc, e.pc);
      end
    end
  endtask

  initial begin
    // Sequential fetch, straddle, flush into upper half, stalls, errors, wrap-around.
    vecs.push_back(mk(0, 0, 32'h0001_4501, 0, 1, 1, 1, 32'h0000_4501, 1, 0, 32'h0000_0000, 1));
    vecs.push_back(mk(0, 0, 32'h0000_0013, 0, 1, 1, 1, 32'h0000_0001, 1, 0, 32'h0000_0002, 0));
    vecs.push_back(mk(0, 0, 32'h0000_0013, 0, 1, 1, 1, 32'h0000_0013, 0, 0, 32'h0000_0004, 1));
    vecs.push_back(mk(0, 0, 32'h0013_4501, 0, 1, 1, 1, 32'h0000_4501, 1, 0, 32'h0000_0008, 1));
    vecs.push_back(mk(0, 0, 32'h4505_0000, 0, 1, 1, 1, 32'h0000_0013, 0, 0, 32'h0000_000A, 1));
    vecs.push_back(mk(0, 0, 32'h0000_0000, 0, 0, 1, 1, 32'h0000_4505, 1, 0, 32'h0000_000E, 0));
    vecs.push_back(mk(1, 32'h0000_0102, 32'hDEAD_BEEF, 0, 1, 1, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 32'h4505_1234, 0, 1, 1, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 32'h0000_0000, 0, 0, 1, 1, 32'h0000_4505, 1, 0, 32'h0000_0102, 0));
    vecs.push_back(mk(0, 0, 32'h0013_4501, 1, 1, 1, 1, 32'h0000_4501, 1, 1, 32'h0000_0104, 1));
    vecs.push_back(mk(0, 0, 32'h0000_0000, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(0, 0, 32'h4501_0000, 0, 1, 0, 1, 32'h0000_0013, 0, 1, 32'h0000_0106, 0));
    vecs.push_back(mk(0, 0, 32'h4501_0000, 0, 1, 1, 1, 32'h0000_0013, 0, 1, 32'h0000_0106, 1));
    vecs.push_back(mk(0, 0, 32'h0000_0000, 0, 0, 1, 1, 32'h0000_4501, 1, 0, 32'h0000_010A, 0));
    vecs.push_back(mk(0, 0, 32'h0013_4501, 0, 1, 1, 1, 32'h0000_4501, 1, 0, 32'h0000_010C, 1));
    vecs.push_back(mk(1, 32'h0000_0200, 32'h1111_2222, 0, 1, 1, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 32'h0000_0093, 0, 1, 1, 1, 32'h0000_0093, 0, 0, 32'h0000_0200, 1));
    vecs.push_back(mk(0, 0, 32'h0000_0013, 0, 1, 0, 1, 32'h0000_0013, 0, 0, 32'h0000_0204, 0));
    vecs.push_back(mk(0, 0, 32'h0000_0013, 0, 1, 1, 1, 32'h0000_0013, 0, 0, 32'h0000_0204, 1));
    vecs.push_back(mk(1, 32'hFFFF_FFFC, 32'h0000_0000, 0, 1, 1, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 32'h0000_0013, 0, 1, 1, 1, 32'h0000_0013, 0, 0, 32'hFFFF_FFFC, 1));
    vecs.push_back(mk(0, 0, 32'h0000_4501, 0, 1, 1, 1, 32'h0000_4501, 1, 0, 32'h0000_0000, 1));
    vecs.push_back(mk(0, 0, 32'h0000_0000, 0, 0, 1, 1, 32'h0000_0000, 1, 0, 32'h0000_0002, 0));
    vecs.push_back(mk(0, 0, 32'h0000_0000, 0, 0, 1, 0, 0, 0, 0, 0, 0));

    // Reset state, with a live fetch word present to show outputs stay quiet.
    resetn     = 1'b0;
    flush      = 1'b0;
    flush_addr = 32'h0;
    fetch_data = 32'h0013_4501;
    fetch_err  = 1'b0;
    fetch_val  = 1'b1;
    instr_rdy  = 1'b1;
    #2;
    chk("reset val", {31'h0, instr_val}, 32'h0);
    chk("reset fetch_rdy", {31'h0, fetch_rdy}, 32'h0);
    chk("reset instr", instr, 32'h0);
    chk("reset pc", instr_pc, 32'h0);
    @(negedge clk);
    fetch_val = 1'b0;
    resetn    = 1'b1;

    for (int i = 0; i < vecs.size(); i++)
      apply(vecs[i], $sformatf("row%0d", i));

    // Reset while a 32-bit half is held: the half is lost, restart at RESET_PC.
    apply(mk(0, 0, 32'h0013_4501, 0, 1, 1, 1, 32'h0000_4501, 1, 0, 32'h0000_0004, 1), "pre_rst");
    @(negedge clk);
    resetn     = 1'b0;
    fetch_data = 32'h0000_0013;
    fetch_val  = 1'b1;
    #2;
    chk("midrst val", {31'h0, instr_val}, 32'h0);
    chk("midrst fetch_rdy", {31'h0, fetch_rdy}, 32'h0);
    chk("midrst pc", instr_pc, 32'h0);
    @(negedge clk);
    fetch_val = 1'b0;
    resetn    = 1'b1;
    apply(mk(0, 0, 32'h0000_0013, 0, 1, 1, 1, 32'h0000_0013, 0, 0, 32'h0000_0000, 1), "post_rst");

    chk("scoreboard drained", sbq.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rvc_aligner.md
Name: rvc_aligner

Overview:
- Sits between instruction fetch and decode.
- Splits 32-bit, word-aligned fetch words into a stream of 16-bit compressed and 32-bit instructions, and stitches 32-bit instructions that straddle two fetch words.
- Tracks the PC of every emitted instruction.
- Emits one instruction per cycle to the decode stage: a compressed instruction goes to the compressed-instruction decoder, a full instruction to the standard decoder.

Parameters:
- RESET_PC, 32'h0000_0000, PC of the first instruction after reset; bit 0 ignored.

Ports:
- s_clk_i  in  1  clock
- s_resetn_i  in  1  asynchronous active-low reset
- s_flush_i  in  1  redirect; discard held state, restart at s_flush_addr_i
- s_flush_addr_i  in  32  redirect target; bit 0 ignored, bit 1 selects the starting halfword
- s_fetch_data_i  in  32  word-aligned fetch data
- s_fetch_err_i  in  1  bus error attached to the fetch word
- s_fetch_val_i  in  1  fetch word valid
- s_fetch_rdy_o  out  1  fetch word consumed this cycle
- s_instr_o  out  32  instruction; upper 16 bits are zero when compressed
- s_instr_rvc_o  out  1  instruction is compressed (bits[1:0] != 2'b11)
- s_instr_err_o  out  1  any halfword of the instruction carried an error
- s_instr_pc_o  out  32  PC of the instruction
- s_instr_val_o  out  1  instruction valid
- s_instr_rdy_i  in  1  decode accepts

Behaviour:
- Reset (async, s_resetn_i=0):
  - state=EMPTY, held halfword=0, held error=0, skip=RESET_PC[1], pc=RESET_PC & ~1.
  - Outputs: s_instr_val_o=0, s_fetch_rdy_o=0, s_instr_o=0, s_instr_pc_o=RESET_PC & ~1.
- Registered state: state {EMPTY, HALF}, hold[15:0], hold_err, skip, pc[31:1].
- Output path is combinational from the fetch inputs and registers. Zero-cycle latency when a fetch word is present; no extra bubble.
- Transfer on s_instr_val_o & s_instr_rdy_i. PC advances by 2 (compressed) or 4 only on a transfer, with 32-bit wrap-around.
- Let F=s_fetch_data_i and lo/hi=F[15:0]/F[31:16].
- EMPTY, skip=1, fetch valid:
  - No output; s_fetch_rdy_o=1.
  - hold<=hi, hold_err<=s_fetch_err_i, skip<=0, state->HALF.
- EMPTY, skip=0, fetch valid, lo compressed:
  - Output {16'b0,lo}.
  - On transfer: s_fetch_rdy_o=1, hold<=hi, state->HALF.
- EMPTY, skip=0, fetch valid, lo full:
  - Output F.
  - On transfer: s_fetch_rdy_o=1, state stays EMPTY.
- HALF, hold compressed:
  - Output {16'b0,hold} regardless of fetch valid; s_fetch_rdy_o=0.
  - On transfer: state->EMPTY.
- HALF, hold full, fetch valid:
  - Output {lo,hold}; error = hold_err | s_fetch_err_i.
  - On transfer: s_fetch_rdy_o=1, hold<=hi, state stays HALF.
- HALF, hold full, fetch not valid: s_instr_val_o=0; wait.
- No output transfer means no state change and s_fetch_rdy_o=0, except the skip case above.
- s_fetch_rdy_o is never asserted while s_fetch_val_i=0.
- Flush has priority over everything in the same cycle:
  - s_instr_val_o=0, s_fetch_rdy_o=1 (the incoming word is dropped).
  - state<=EMPTY, skip<=s_flush_addr_i[1], pc<=s_flush_addr_i & ~1.
  - The next fetch word is the aligned word containing the target.
- Error fetch word whose lo is compressed: lo is emitted with err=1, and hi is still held with err=1.
- Reset mid-stitch: the held halfword is lost; restart at RESET_PC.

Decomposition:
- Shared package p_hardisc: typedef enum align_state {ALIGN_EMPTY, ALIGN_HALF}, and function is_rvc(logic[1:0]) returning bits != 2'b11.
- No sub-module. A single always_ff for the registers plus a combinational next-state/output block.

Test Plan:
- RESET_PC=0, fetch 32'h0001_4501, 32'h0000_0013, rdy=1:
  - emits 16'h4501 rvc at pc=0 and 16'h0001 rvc at pc=2;
  - fetch_rdy stays 0 on the cycle 16'h0001 is emitted from hold;
  - then 32'h0000_0013 at pc=4.
- Straddle: fetch 32'h0013_4501 then 32'h4505_0000:
  - outputs 16'h4501 at pc=0;
  - then 32'h0000_0013 at pc=2, stitched lo of word 2 over hold 16'h0013;
  - then 16'h4505 at pc=6.
- Flush to 32'h0000_0102 with next fetch 32'h4505_1234:
  - the 16'h1234 half is skipped with no output;
  - 16'h4505 is emitted at pc=0x102.
- Back-pressure: s_instr_rdy_i=0 for 3 cycles while HALF holding a full-instruction half:
  - s_instr_o stable, s_fetch_rdy_o=0, pc unchanged;
  - the stitched instruction is accepted on the cycle rdy rises.
- Error propagation: hold 16'h0013 (err=1) plus next word lo=16'h0000 (err=0) -> s_instr_err_o=1 on the stitched instruction.
- Flush asserted while HALF with fetch valid:
  - no output, fetch word dropped (fetch_rdy=1);
  - next cycle state=EMPTY, pc=target.
